// File: rtl/quad_encoder_bank_if.sv
`default_nettype none
// ============================================================================
// Interface : quad_encoder_bank_if
// Purpose   : encoder inputs, clear/latch controls and snapshot read port
// Revision  : 1.0
// ============================================================================
interface quad_encoder_bank_if #(
  parameter int CHANNELS = 2,
  parameter int SIZE     = 16,
  parameter int SEL_W    = 1
);
  logic [CHANNELS-1:0] enc_a;
  logic [CHANNELS-1:0] enc_b;
  logic [CHANNELS-1:0] clear;
  logic                latch;
  logic [SEL_W-1:0]    sel;
  logic [SIZE-1:0]     count;
  logic                valid;
  logic [CHANNELS-1:0] err;

  modport master (
    output enc_a, enc_b, clear, latch, sel,
    input  count, valid, err
  );

  modport slave (
    input  enc_a, enc_b, clear, latch, sel,
    output count, valid, err
  );
endinterface
`default_nettype wire

// File: rtl/quad_encoder_bank.sv
`default_nettype none
// ============================================================================
// Module   : quad_encoder_bank
// Purpose  : multi-channel x4 quadrature counters with coherent snapshot reads
// Revision : 1.0
// ============================================================================
module quad_encoder_bank #(
  parameter int CHANNELS = 2,
  parameter int SIZE     = 16,
  parameter int FILTER   = 3,
  parameter int SEL_W    = 1
) (
  input  logic               clk,
  input  logic               rst,
  quad_encoder_bank_if.slave bus
);
  localparam int               RUN_W   = $clog2(FILTER + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FILTER);
  localparam int               SLOTS   = 2 ** SEL_W;

  logic [SIZE-1:0]     snap_w [CHANNELS];
  logic [CHANNELS-1:0] err_w;
  logic [SIZE-1:0]     mux_w  [SLOTS];
  logic                valid_q;
  logic                valid_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    // Phase vectors are packed as {A, B}.
    logic [1:0]            s1_q, s1_d, s2_q, s2_d, last_q, last_d;
    logic [1:0][RUN_W-1:0] run_q, run_d;
    logic [1:0]            f_q, f_d, f_prev_q, f_prev_d, ok_q, ok_d;
    logic                  init_q, init_d;
    logic [SIZE-1:0]       counter_q, counter_d, snap_q, snap_d;
    logic                  err_q, err_d;
    logic [1:0]            pos_now, pos_prev, delta;
    logic                  step_up, step_dn, bad;

    always_comb begin
      s1_d   = {bus.enc_a[i], bus.enc_b[i]};
      s2_d   = s1_q;
      last_d = s2_q;
      f_d    = f_q;
      ok_d   = ok_q;
      run_d  = run_q;
      // Run length of the current s2 value; f follows once it reaches FILTER.
      for (int p = 0; p < 2; p++) begin
        if (s2_q[p] == last_q[p]) begin
          run_d[p] = (run_q[p] == RUN_MAX) ? RUN_MAX : run_q[p] + 1'b1;
        end else begin
          run_d[p] = RUN_W'(1);
        end
        if (run_d[p] == RUN_MAX) begin
          f_d[p]  = s2_q[p];
          ok_d[p] = 1'b1;
        end
      end

      f_prev_d = f_q;
      init_d   = init_q | (&ok_q);

      // Gray {A,B} 00,10,11,01 maps to positions 0,1,2,3.
      pos_now  = {f_q[0], f_q[1] ^ f_q[0]};
      pos_prev = {f_prev_q[0], f_prev_q[1] ^ f_prev_q[0]};
      delta    = pos_now - pos_prev;
      step_up  = init_q && (delta == 2'd1);
      step_dn  = init_q && (delta == 2'd3);
      bad      = init_q && (delta == 2'd2);

      counter_d = counter_q;
      err_d     = err_q;
      if (bus.clear[i]) begin
        counter_d = '0;
        err_d     = 1'b0;
      end else begin
        if (step_up) counter_d = counter_q + SIZE'(1);
        if (step_dn) counter_d = counter_q - SIZE'(1);
        if (bad)     err_d     = 1'b1;
      end

      snap_d = bus.latch ? counter_q : snap_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_q      <= '0;
        s2_q      <= '0;
        last_q    <= '0;
        run_q     <= '0;
        f_q       <= '0;
        f_prev_q  <= '0;
        ok_q      <= '0;
        init_q    <= 1'b0;
        counter_q <= '0;
        snap_q    <= '0;
        err_q     <= 1'b0;
      end else begin
        s1_q      <= s1_d;
        s2_q      <= s2_d;
        last_q    <= last_d;
        run_q     <= run_d;
        f_q       <= f_d;
        f_prev_q  <= f_prev_d;
        ok_q      <= ok_d;
        init_q    <= init_d;
        counter_q <= counter_d;
        snap_q    <= snap_d;
        err_q     <= err_d;
      end
    end

    assign snap_w[i] = snap_q;
    assign err_w[i]  = err_q;
  end

  always_comb begin
    valid_d = bus.latch;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Unused select codes read as zero.
  for (genvar j = 0; j < SLOTS; j++) begin : g_mux
    if (j < CHANNELS) begin : g_live
      assign mux_w[j] = snap_w[j];
    end else begin : g_pad
      assign mux_w[j] = '0;
    end
  end

  assign bus.count = mux_w[bus.sel];
  assign bus.valid = valid_q;
  assign bus.err   = err_w;
endmodule
`default_nettype wire

// File: tb/tb_quad_encoder_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_quad_encoder_bank
// Purpose  : scoreboard bench for quad_encoder_bank (3 channels, 8-bit)
// Revision : 1.0
// ============================================================================
module tb_quad_encoder_bank;
  localparam int CH = 3;
  localparam int SZ = 8;
  localparam int FL = 3;
  localparam int SW = 2;
  localparam int NS = 4;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [SZ-1:0] exp_cnt [CH];
  logic [1:0]    pos     [CH];
  logic [CH-1:0] exp_err;
  logic [SZ-1:0] sb [$];
  logic [SZ-1:0] e;

  quad_encoder_bank_if #(.CHANNELS(CH), .SIZE(SZ), .SEL_W(SW)) bus ();

  quad_encoder_bank #(.CHANNELS(CH), .SIZE(SZ), .FILTER(FL), .SEL_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic drive_enc(input int ch);
    bus.enc_a[ch] = pos[ch][1] ^ pos[ch][0];
    bus.enc_b[ch] = pos[ch][1];
  endtask

  task automatic step(input int ch, input bit up);
    @(negedge clk);
    pos[ch] = up ? pos[ch] + 2'd1 : pos[ch] - 2'd1;
    drive_enc(ch);
    repeat (FL + 3) @(negedge clk);
    exp_cnt[ch] = up ? exp_cnt[ch] + 1'b1 : exp_cnt[ch] - 1'b1;
  endtask

  task automatic do_clear(input int ch);
    @(negedge clk);
    bus.clear[ch] = 1'b1;
    @(negedge clk);
    bus.clear[ch] = 1'b0;
    exp_cnt[ch] = '0;
    exp_err[ch] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < CH; c++) drive_enc(c);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    for (int c = 0; c < CH; c++) exp_cnt[c] = '0;
    exp_err = '0;
  endtask

  task automatic push_snap();
    for (int s = 0; s < NS; s++) begin
      if (s < CH) sb.push_back(exp_cnt[s]);
      else        sb.push_back('0);
    end
  endtask

  // Returns at the falling edge inside the cycle following the latch edge.
  task automatic latch_pulse();
    @(negedge clk);
    bus.latch = 1'b1;
    push_snap();
    @(negedge clk);
    bus.latch = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
    n_tests++;
    if (bus.err !== '0) begin n_fail++; $display("FAIL reset_err: got %b expected 000", bus.err); end
    for (int s = 0; s < NS; s++) begin
      bus.sel = s[SW-1:0];
      #1;
      n_tests++;
      if (bus.count !== '0) begin n_fail++; $display("FAIL reset_count sel=%0d: got %0d expected 0", s, bus.count); end
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_first_step();
    @(negedge clk);
    pos[0] = 2'd1;
    drive_enc(0);
    repeat (5) @(negedge clk);
    bus.latch = 1'b1;
    push_snap();
    @(negedge clk);
    exp_cnt[0] = exp_cnt[0] + 1'b1;
    push_snap();
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL first_valid%0d: got %b expected 1", k, bus.valid); end
      for (int s = 0; s < NS; s++) begin
        e = sb.pop_front();
        bus.sel = s[SW-1:0];
        #1;
        n_tests++;
        if (bus.count !== e) begin n_fail++; $display("FAIL first_snap%0d sel=%0d: got %0d expected %0d", k, s, bus.count, e); end
      end
      if (k == 0) @(negedge clk);
    end
    bus.latch = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL first_valid_end: got %b expected 0", bus.valid); end
  endtask

  task automatic test_two_channel();
    do_clear(0);
    for (int k = 0; k < 40; k++) step(1, 1'b1);
    for (int k = 0; k < 15; k++) step(1, 1'b0);
    latch_pulse();
    n_tests++;
    if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL two_valid: got %b expected 1", bus.valid); end
    for (int s = 0; s < NS; s++) begin
      e = sb.pop_front();
      bus.sel = s[SW-1:0];
      #1;
      n_tests++;
      if (bus.count !== e) begin n_fail++; $display("FAIL two_snap sel=%0d: got %0d expected %0d", s, bus.count, e); end
    end
  endtask

  task automatic test_wrap();
    do_clear(0);
    for (int k = 0; k < 257; k++) step(0, 1'b1);
    latch_pulse();
    for (int s = 0; s < NS; s++) begin
      e = sb.pop_front();
      bus.sel = s[SW-1:0];
      #1;
      n_tests++;
      if (bus.count !== e) begin n_fail++; $display("FAIL wrap_up sel=%0d: got %0d expected %0d", s, bus.count, e); end
    end
    do_clear(0);
    step(0, 1'b0);
    latch_pulse();
    for (int s = 0; s < NS; s++) begin
      e = sb.pop_front();
      bus.sel = s[SW-1:0];
      #1;
      n_tests++;
      if (bus.count !== e) begin n_fail++; $display("FAIL wrap_down sel=%0d: got %0d expected %0d", s, bus.count, e); end
    end
    n_tests++;
    if (bus.err !== exp_err) begin n_fail++; $display("FAIL wrap_err: got %b expected %b", bus.err, exp_err); end
  endtask

  task automatic test_glitch_error();
    for (int c = 0; c < CH; c++) pos[c] = 2'd0;
    do_reset();
    @(negedge clk);
    bus.enc_a[0] = 1'b1;
    repeat (2) @(negedge clk);
    bus.enc_a[0] = 1'b0;
    repeat (10) @(negedge clk);
    latch_pulse();
    for (int s = 0; s < NS; s++) begin
      e = sb.pop_front();
      bus.sel = s[SW-1:0];
      #1;
      n_tests++;
      if (bus.count !== e) begin n_fail++; $display("FAIL glitch_snap sel=%0d: got %0d expected %0d", s, bus.count, e); end
    end
    n_tests++;
    if (bus.err !== exp_err) begin n_fail++; $display("FAIL glitch_err: got %b expected %b", bus.err, exp_err); end
    step(0, 1'b1);
    step(0, 1'b1);
    // 11 -> 00 changes both phases at once.
    @(negedge clk);
    pos[0] = 2'd0;
    drive_enc(0);
    repeat (FL + 3) @(negedge clk);
    exp_err[0] = 1'b1;
    n_tests++;
    if (bus.err !== exp_err) begin n_fail++; $display("FAIL double_err: got %b expected %b", bus.err, exp_err); end
    latch_pulse();
    for (int s = 0; s < NS; s++) begin
      e = sb.pop_front();
      bus.sel = s[SW-1:0];
      #1;
      n_tests++;
      if (bus.count !== e) begin n_fail++; $display("FAIL double_snap sel=%0d: got %0d expected %0d", s, bus.count, e); end
    end
    do_clear(0);
    n_tests++;
    if (bus.err !== exp_err) begin n_fail++; $display("FAIL clear_err: got %b expected %b", bus.err, exp_err); end
    step(0, 1'b1);
    latch_pulse();
    for (int s = 0; s < NS; s++) begin
      e = sb.pop_front();
      bus.sel = s[SW-1:0];
      #1;
      n_tests++;
      if (bus.count !== e) begin n_fail++; $display("FAIL after_err_snap sel=%0d: got %0d expected %0d", s, bus.count, e); end
    end
  endtask

  task automatic test_power_up_11();
    pos[0] = 2'd2;
    do_reset();
    n_tests++;
    if (bus.err !== exp_err) begin n_fail++; $display("FAIL pwr11_err: got %b expected %b", bus.err, exp_err); end
    latch_pulse();
    for (int s = 0; s < NS; s++) begin
      e = sb.pop_front();
      bus.sel = s[SW-1:0];
      #1;
      n_tests++;
      if (bus.count !== e) begin n_fail++; $display("FAIL pwr11_idle sel=%0d: got %0d expected %0d", s, bus.count, e); end
    end
    step(0, 1'b1);
    latch_pulse();
    for (int s = 0; s < NS; s++) begin
      e = sb.pop_front();
      bus.sel = s[SW-1:0];
      #1;
      n_tests++;
      if (bus.count !== e) begin n_fail++; $display("FAIL pwr11_step sel=%0d: got %0d expected %0d", s, bus.count, e); end
    end
  endtask

  task automatic test_latch_clear_same_edge();
    for (int k = 0; k < 3; k++) step(0, 1'b1);
    @(negedge clk);
    pos[0] = pos[0] + 2'd1;
    drive_enc(0);
    repeat (5) @(negedge clk);
    bus.latch    = 1'b1;
    bus.clear[0] = 1'b1;
    push_snap();
    @(negedge clk);
    bus.latch    = 1'b0;
    bus.clear[0] = 1'b0;
    exp_cnt[0]   = '0;
    n_tests++;
    if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL same_edge_valid: got %b expected 1", bus.valid); end
    for (int s = 0; s < NS; s++) begin
      e = sb.pop_front();
      bus.sel = s[SW-1:0];
      #1;
      n_tests++;
      if (bus.count !== e) begin n_fail++; $display("FAIL same_edge_snap sel=%0d: got %0d expected %0d", s, bus.count, e); end
    end
    @(negedge clk);
    n_tests++;
    if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL same_edge_valid_end: got %b expected 0", bus.valid); end
    latch_pulse();
    for (int s = 0; s < NS; s++) begin
      e = sb.pop_front();
      bus.sel = s[SW-1:0];
      #1;
      n_tests++;
      if (bus.count !== e) begin n_fail++; $display("FAIL same_edge_after sel=%0d: got %0d expected %0d", s, bus.count, e); end
    end
    step(0, 1'b1);
    latch_pulse();
    for (int s = 0; s < NS; s++) begin
      e = sb.pop_front();
      bus.sel = s[SW-1:0];
      #1;
      n_tests++;
      if (bus.count !== e) begin n_fail++; $display("FAIL same_edge_next sel=%0d: got %0d expected %0d", s, bus.count, e); end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    pos[1] = pos[1] + 2'd2;
    drive_enc(1);
    repeat (FL + 3) @(negedge clk);
    exp_err[1] = 1'b1;
    n_tests++;
    if (bus.err !== exp_err) begin n_fail++; $display("FAIL async_pre_err: got %b expected %b", bus.err, exp_err); end
    bus.sel   = 2'd0;
    bus.latch = 1'b1;
    @(posedge clk);
    #2;
    bus.latch = 1'b0;
    n_tests++;
    if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL async_pre_valid: got %b expected 1", bus.valid); end
    n_tests++;
    if (bus.count !== exp_cnt[0]) begin n_fail++; $display("FAIL async_pre_count: got %0d expected %0d", bus.count, exp_cnt[0]); end
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b expected 0", bus.valid); end
    n_tests++;
    if (bus.err !== '0) begin n_fail++; $display("FAIL async_err: got %b expected 000", bus.err); end
    for (int s = 0; s < CH; s++) begin
      bus.sel = s[SW-1:0];
      #1;
      n_tests++;
      if (bus.count !== '0) begin n_fail++; $display("FAIL async_count sel=%0d: got %0d expected 0", s, bus.count); end
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    bus.enc_a = '0;
    bus.enc_b = '0;
    bus.clear = '0;
    bus.latch = 1'b0;
    bus.sel   = '0;
    exp_err   = '0;
    for (int c = 0; c < CH; c++) begin
      exp_cnt[c] = '0;
      pos[c]     = 2'd0;
    end
    test_reset();
    test_first_step();
    test_two_channel();
    test_wrap();
    test_glitch_error();
    test_power_up_11();
    test_latch_clear_same_edge();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
